// File: rtl/if_prefetch_pkg.sv
// Shared CPU core definitions used by the instruction prefetch stage and the decoder.
//   AddrW / ByteW     : address and data widths of the byte memory port
//   StIdle..StDiscard : fetch state encoding
//   OpNop, LenMin/Max : NOP opcode and instruction length bounds shared with the decoder
//   eff_len()         : maps a decoder length of 0 onto 1
package if_prefetch_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned ByteW = 8;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  localparam logic [ByteW-1:0] OpNop  = 8'hEA;
  localparam logic [1:0]       LenMin = 2'd1;
  localparam logic [1:0]       LenMax = 2'd3;

  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == 2'd0) ? LenMin : len;
  endfunction

endpackage

// File: rtl/if_byte_queue.sv
// Circular byte buffer for the prefetch stage.
//   clk, a_rst          : clock, synchronous active-high reset
//   flush               : drops all entries (pointers and count to zero)
//   push, push_data     : append one byte at the tail
//   pop, pop_len        : remove pop_len (1..3) bytes from the head; caller guarantees count >= pop_len
//   count               : number of valid bytes
//   peek0..peek2        : head, head+1, head+2; bytes at or beyond the tail read as zero
module if_byte_queue
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [ByteW-1:0] push_data,
  input  logic             pop,
  input  logic [1:0]       pop_len,
  output logic [CntW-1:0]  count,
  output logic [ByteW-1:0] peek0,
  output logic [ByteW-1:0] peek1,
  output logic [ByteW-1:0] peek2
);

  logic [ByteW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  head_q;
  logic [PtrW-1:0]  tail_q;
  logic [CntW-1:0]  count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_data;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop) begin
        head_q <= head_q + PtrW'(pop_len);
      end
      count_q <= count_q + CntW'(push) - (pop ? CntW'(pop_len) : CntW'(0));
    end
  end

  assign count = count_q;
  assign peek0 = (count_q > CntW'(0)) ? mem_q[head_q]              : '0;
  assign peek1 = (count_q > CntW'(1)) ? mem_q[head_q + PtrW'(1)]   : '0;
  assign peek2 = (count_q > CntW'(2)) ? mem_q[head_q + PtrW'(2)]   : '0;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch stage feeding the decoder from an 8-bit memory port.
//   clk, a_rst                 : clock, synchronous active-high reset
//   mem_addr, mem_rd           : byte read request, held stable until mem_ack
//   mem_ack, mem_data          : read completion and data
//   id_opcode, id_k16, id_pc   : head instruction presented to the decoder
//   id_len                     : decoder-supplied length (0 treated as 1)
//   id_valid, id_take          : head instruction complete / consumed
//   ex_redirect, ex_redirect_pc: flush and refetch from a new PC
//   perf_starve                : only with IF_PERF_EN; saturating count of starved cycles
// Optional feature macro: IF_PERF_EN.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [AddrW-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             a_rst,
  output logic [AddrW-1:0] mem_addr,
  output logic             mem_rd,
  input  logic             mem_ack,
  input  logic [ByteW-1:0] mem_data,
  output logic [ByteW-1:0] id_opcode,
  output logic [15:0]      id_k16,
  output logic [AddrW-1:0] id_pc,
  input  logic [1:0]       id_len,
  output logic             id_valid,
  input  logic             id_take,
  input  logic             ex_redirect,
  input  logic [AddrW-1:0] ex_redirect_pc
`ifdef IF_PERF_EN
  ,
  output logic [15:0]      perf_starve
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [AddrW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrW-1:0] id_pc_q, id_pc_d;
  logic [AddrW-1:0] req_addr_q;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  count_next;
  logic [ByteW-1:0] peek0, peek1, peek2;
  logic [1:0]       len_eff;
  logic             push;
  logic             pop;

  assign len_eff  = eff_len(id_len);
  assign id_valid = (count >= CntW'(len_eff));
  // Redirect overrides both the pop and the push of the same cycle.
  assign pop      = id_take && id_valid && !ex_redirect;
  assign push     = mem_ack && (state_q == StFetch) && !ex_redirect;
  assign mem_rd   = (state_q == StFetch) || (state_q == StDiscard);
  // While discarding, the abandoned request keeps its original address.
  assign mem_addr = (state_q == StDiscard) ? req_addr_q : fetch_pc_q;

  assign count_next = count + CntW'(push) - (pop ? CntW'(len_eff) : CntW'(0));

  assign id_opcode = peek0;
  assign id_k16    = {(len_eff == 2'd3) ? peek2 : 8'h00, (len_eff >= 2'd2) ? peek1 : 8'h00};
  assign id_pc     = id_pc_q;

  if_byte_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .a_rst    (a_rst),
    .flush    (ex_redirect),
    .push     (push),
    .push_data(mem_data),
    .pop      (pop),
    .pop_len  (len_eff),
    .count    (count),
    .peek0    (peek0),
    .peek1    (peek1),
    .peek2    (peek2)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    id_pc_d    = id_pc_q;
    if (ex_redirect) begin
      fetch_pc_d = ex_redirect_pc;
      id_pc_d    = ex_redirect_pc;
      // A read still outstanding must be drained before a new one may issue.
      if (mem_rd && !mem_ack) begin
        state_d = StDiscard;
      end else begin
        state_d = StFetch;
      end
    end else begin
      if (pop) begin
        id_pc_d = id_pc_q + AddrW'(len_eff);
      end
      unique case (state_q)
        StIdle: begin
          if (count < CntW'(DEPTH)) begin
            state_d = StFetch;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            fetch_pc_d = fetch_pc_q + AddrW'(1);
            state_d    = (count_next < CntW'(DEPTH)) ? StFetch : StIdle;
          end
        end
        StDiscard: begin
          if (mem_ack) begin
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      id_pc_q    <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      id_pc_q    <= id_pc_d;
      if (state_q != StDiscard) begin
        req_addr_q <= fetch_pc_q;
      end
    end
  end

`ifdef IF_PERF_EN
  logic [15:0] starve_q;

  always_ff @(posedge clk) begin
    if (a_rst) begin
      starve_q <= '0;
    end else if (!id_valid && !ex_redirect && (starve_q != 16'hFFFF)) begin
      starve_q <= starve_q + 16'd1;
    end
  end

  assign perf_starve = starve_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        a_rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  id_opcode;
  logic [15:0] id_k16;
  logic [15:0] id_pc;
  logic [1:0]  id_len;
  logic        id_valid;
  logic        id_take;
  logic        ex_redirect;
  logic [15:0] ex_redirect_pc;

  always #5 clk = ~clk;

  if_prefetch #(
    .DEPTH   (4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk           (clk),
    .a_rst         (a_rst),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .id_opcode     (id_opcode),
    .id_k16        (id_k16),
    .id_pc         (id_pc),
    .id_len        (id_len),
    .id_valid      (id_valid),
    .id_take       (id_take),
    .ex_redirect   (ex_redirect),
    .ex_redirect_pc(ex_redirect_pc)
  );

  // Zero-wait memory: acks in the same cycle unless stalled.
  logic [7:0] mem_img [65536];
  logic       stall;
  assign mem_ack  = mem_rd && !stall;
  assign mem_data = mem_img[mem_addr];

  // Decoder length table (0 exercises the treat-as-1 rule).
  function automatic logic [1:0] len_of(input logic [7:0] op);
    case (op)
      8'hA9:   return 2'd2;
      8'h4C:   return 2'd3;
      8'h00:   return 2'd0;
      default: return 2'd1;
    endcase
  endfunction
  assign id_len = len_of(id_opcode);

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] k16;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        sb_e;
  logic [15:0] acked[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every instruction the decoder consumes.
  always @(negedge clk) begin
    if (!a_rst && id_valid && id_take && !ex_redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got take at pc %0h expected none", id_pc);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_opcode", {24'b0, id_opcode}, {24'b0, sb_e.op});
        chk("sb_k16", {16'b0, id_k16}, {16'b0, sb_e.k16});
        chk("sb_pc", {16'b0, id_pc}, {16'b0, sb_e.pc});
      end
    end
    if (!a_rst && mem_rd && mem_ack && !ex_redirect) acked.push_back(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [7:0] op, input logic [15:0] k16,
                              input logic [15:0] pc);
    exp_t e;
    e.op  = op;
    e.k16 = k16;
    e.pc  = pc;
    exp_q.push_back(e);
  endtask

  task automatic take_one();
    int n = 0;
    while (!id_valid && n < 20) begin
      step();
      n++;
    end
    if (!id_valid) begin
      checks++;
      errors++;
      $display("FAIL take_timeout: got id_valid 0 expected 1 within 20 cycles");
    end else begin
      id_take = 1'b1;
      step();
      id_take = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem_img[i] = OpNop;
    mem_img[0] = 8'hA9; mem_img[1] = 8'h34; mem_img[2] = 8'h12; mem_img[3] = 8'hEA;
    mem_img[4] = 8'hE8; mem_img[5] = 8'hC8; mem_img[6] = 8'hCA; mem_img[7] = 8'h88;
    a_rst = 1'b1; id_take = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0; stall = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_mem_rd", {31'b0, mem_rd}, 0);
    chk("rst_id_valid", {31'b0, id_valid}, 0);
    chk("rst_id_opcode", {24'b0, id_opcode}, 0);
    chk("rst_id_k16", {16'b0, id_k16}, 0);
    chk("rst_id_pc", {16'b0, id_pc}, 0);
    a_rst = 1'b0;
    acked.delete();

    // First instruction A9 34 (len 2): valid two cycles after mem_rd rises
    n = 0;
    while (!mem_rd && n < 8) begin
      step();
      n++;
    end
    chk("first_req", {31'b0, mem_rd}, 1);
    chk("lat_c0_valid", {31'b0, id_valid}, 0);
    step();
    chk("lat_c1_valid", {31'b0, id_valid}, 0);
    chk("partial_opcode", {24'b0, id_opcode}, 32'hA9);
    chk("partial_k16", {16'b0, id_k16}, 0);
    step();
    chk("lat_c2_valid", {31'b0, id_valid}, 1);
    chk("t1_k16", {16'b0, id_k16}, 32'h0034);
    chk("t1_pc", {16'b0, id_pc}, 0);

    // Fill to DEPTH with no take: exactly four requests, then idle
    repeat (4) step();
    chk("full_mem_rd", {31'b0, mem_rd}, 0);
    chk("full_acks", acked.size(), 4);
    repeat (3) step();
    chk("full_no_fifth", acked.size(), 4);
    chk("full_mem_rd_hold", {31'b0, mem_rd}, 0);

    expect_instr(8'hA9, 16'h0034, 16'h0000);
    take_one();
    chk("t1_pc_after", {16'b0, id_pc}, 32'h0002);

    // Simultaneous push and pop at 3 entries; nothing lost
    repeat (6) step();
    stall = 1'b1;
    expect_instr(8'h12, 16'h0000, 16'h0002);
    take_one();
    repeat (2) step();
    chk("pend_mem_rd", {31'b0, mem_rd}, 1);
    chk("pend_addr", {16'b0, mem_addr}, 32'h0006);
    expect_instr(8'hEA, 16'h0000, 16'h0003);
    stall = 1'b0;
    id_take = 1'b1;
    step();
    stall = 1'b1;
    id_take = 1'b0;
    chk("pushpop_next_addr", {16'b0, mem_addr}, 32'h0007);
    expect_instr(8'hE8, 16'h0000, 16'h0004);
    take_one();
    expect_instr(8'hC8, 16'h0000, 16'h0005);
    take_one();
    expect_instr(8'hCA, 16'h0000, 16'h0006);
    take_one();

    // Redirect with a read pending and no ack: discard the late byte
    chk("pre_redir_valid", {31'b0, id_valid}, 0);
    ex_redirect = 1'b1;
    ex_redirect_pc = 16'h8000;
    step();
    ex_redirect = 1'b0;
    chk("disc_mem_rd", {31'b0, mem_rd}, 1);
    chk("disc_addr_held", {16'b0, mem_addr}, 32'h0007);
    chk("disc_id_pc", {16'b0, id_pc}, 32'h8000);
    chk("disc_valid", {31'b0, id_valid}, 0);
    stall = 1'b0;
    step();
    stall = 1'b1;
    chk("redir_mem_rd", {31'b0, mem_rd}, 1);
    chk("redir_addr", {16'b0, mem_addr}, 32'h8000);
    chk("redir_dropped", {31'b0, id_valid}, 0);
    stall = 1'b0;
    expect_instr(8'hEA, 16'h0000, 16'h8000);
    take_one();

    // PC wrap at 0xFFFF with a 3-byte instruction, then a length-0 opcode
    mem_img[16'hFFFF] = 8'h4C; mem_img[0] = 8'h00; mem_img[1] = 8'hC0;
    mem_img[2] = 8'h00; mem_img[3] = 8'hEA;
    ex_redirect = 1'b1;
    ex_redirect_pc = 16'hFFFF;
    step();
    ex_redirect = 1'b0;
    acked.delete();
    repeat (6) step();
    chk("wrap_acks", acked.size(), 4);
    if (acked.size() == 4) begin
      chk("wrap_addr0", {16'b0, acked[0]}, 32'hFFFF);
      chk("wrap_addr1", {16'b0, acked[1]}, 32'h0000);
      chk("wrap_addr2", {16'b0, acked[2]}, 32'h0001);
    end
    chk("wrap_valid", {31'b0, id_valid}, 1);
    chk("wrap_k16", {16'b0, id_k16}, 32'hC000);
    expect_instr(8'h4C, 16'hC000, 16'hFFFF);
    take_one();
    chk("wrap_pc_after", {16'b0, id_pc}, 32'h0002);
    expect_instr(8'h00, 16'h0000, 16'h0002);
    take_one();
    chk("len0_pc_after", {16'b0, id_pc}, 32'h0003);

    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
